// File: rtl/sram_stage_sequencer_pkg.sv
// seq_pkg: state encoding and stage-selection helper shared by the sequencer and its SRAM mux
package seq_pkg;
  localparam int MAX_STAGES = 32;
  typedef enum logic [2:0] {S_IDLE, S_UART_RX, S_STAGE_START, S_STAGE_RUN, S_ERROR} top_state_type;
  // lowest set bit of mask at or above from; MAX_STAGES when there is none
  function automatic int next_enabled(input logic [MAX_STAGES-1:0] mask, input int from);
    next_enabled = MAX_STAGES;
    for (int i = MAX_STAGES - 1; i >= 0; i--)
      if (i >= from && mask[i]) next_enabled = i;
  endfunction
endpackage

// File: rtl/sram_stage_sequencer_mux.sv
// sram_client_mux: picks which client (VGA, UART or one stage) drives the single SRAM port
module sram_client_mux
  import seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int AW         = 2
) (
  input  top_state_type                i_state,
  input  logic [AW-1:0]                i_index,
  input  logic [ADDR_W-1:0]            i_vga_address,
  input  logic [ADDR_W-1:0]            i_uart_address,
  input  logic [DATA_W-1:0]            i_uart_write_data,
  input  logic                         i_uart_we_n,
  input  logic [NUM_STAGES*ADDR_W-1:0] i_stage_address,
  input  logic [NUM_STAGES*DATA_W-1:0] i_stage_write_data,
  input  logic [NUM_STAGES-1:0]        i_stage_we_n,
  output logic [ADDR_W-1:0]            o_address,
  output logic [DATA_W-1:0]            o_write_data,
  output logic                         o_we_n
);
  logic w_uart, w_stage;
  assign w_uart = i_state == S_UART_RX;
  assign w_stage = i_state == S_STAGE_START || i_state == S_STAGE_RUN;
  assign o_address = w_uart ? i_uart_address : w_stage ? i_stage_address[i_index*ADDR_W +: ADDR_W] : i_vga_address;
  assign o_write_data = w_uart ? i_uart_write_data : w_stage ? i_stage_write_data[i_index*DATA_W +: DATA_W] : '0;
  // a stage may not write during its start cycle
  assign o_we_n = w_uart ? i_uart_we_n : i_state == S_STAGE_RUN ? i_stage_we_n[i_index] : 1'b1;
endmodule

// File: rtl/sram_stage_sequencer.sv
// sram_stage_sequencer: sequences UART load -> enabled decode stages -> VGA display,
// with a per-stage watchdog, and arbitrates the single SRAM port.
module sram_stage_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int UART_TIMEOUT = 50000000,
  parameter int STAGE_WDOG   = 0,
  localparam int AW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         UART_RX_I,
  input  logic [ADDR_W-1:0]            UART_SRAM_address,
  input  logic [DATA_W-1:0]            UART_SRAM_write_data,
  input  logic                         UART_SRAM_we_n,
  input  logic [ADDR_W-1:0]            VGA_SRAM_address,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_write_data,
  input  logic [NUM_STAGES-1:0]        stage_we_n,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES-1:0]        stage_enable_mask,
  output logic [NUM_STAGES-1:0]        stage_start,
  output logic                         UART_rx_initialize,
  output logic                         UART_rx_enable,
  output logic                         VGA_enable,
  output logic [ADDR_W-1:0]            SRAM_address,
  output logic [DATA_W-1:0]            SRAM_write_data,
  output logic                         SRAM_we_n,
  output logic                         busy,
  output logic                         error,
  output logic [AW-1:0]                active_stage
);
  localparam int UW = $clog2(UART_TIMEOUT + 1);
  localparam int WW = STAGE_WDOG > 0 ? $clog2(STAGE_WDOG + 1) : 1;
  top_state_type r_state, w_next;
  logic [AW-1:0] r_active, w_next_active;
  logic [NUM_STAGES-1:0] r_mask, r_start, w_start;
  logic [UW-1:0] r_uart_timer;
  logic [WW-1:0] r_stage_timer;
  logic r_vga, r_init, r_rx_en, r_busy, r_error;
  logic w_vga, w_init, w_rx_en, w_busy, w_error;
  logic w_timeout, w_done, w_wdog;
  int w_first, w_after;
  // a write in the final idle cycle still restarts the idle count
  assign w_timeout = r_uart_timer == UW'(UART_TIMEOUT - 1) && UART_SRAM_we_n;
  assign w_done = stage_done[r_active];
  assign w_wdog = STAGE_WDOG > 0 && r_stage_timer == WW'(STAGE_WDOG - 1);
  assign w_first = next_enabled(MAX_STAGES'(stage_enable_mask), 0);
  assign w_after = next_enabled(MAX_STAGES'(r_mask), int'(r_active) + 1);
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_active <= '0;
      r_mask <= '0;
      r_uart_timer <= '0;
      r_stage_timer <= '0;
      r_vga <= 1'b1;
      r_init <= 1'b0;
      r_rx_en <= 1'b0;
      r_busy <= 1'b0;
      r_error <= 1'b0;
      r_start <= '0;
    end else begin
      r_state <= w_next;
      r_active <= w_next_active;
      r_mask <= r_state == S_UART_RX && w_timeout ? stage_enable_mask : r_mask;
      r_uart_timer <= r_state == S_UART_RX && UART_SRAM_we_n ? r_uart_timer + 1'b1 : '0;
      r_stage_timer <= r_state == S_STAGE_RUN ? r_stage_timer + 1'b1 : '0;
      r_vga <= w_vga;
      r_init <= w_init;
      r_rx_en <= w_rx_en;
      r_busy <= w_busy;
      r_error <= w_error;
      r_start <= w_start;
    end
  end
  always_comb begin
    w_next = r_state;
    w_next_active = r_active;
    case (r_state)
      S_IDLE, S_ERROR: w_next = UART_RX_I ? r_state : S_UART_RX;
      S_UART_RX: if (w_timeout) begin
        w_next = w_first < NUM_STAGES ? S_STAGE_START : S_IDLE;
        w_next_active = w_first < NUM_STAGES ? AW'(w_first) : r_active;
      end
      S_STAGE_START: w_next = S_STAGE_RUN;
      S_STAGE_RUN: if (w_done) begin
        w_next = w_after < NUM_STAGES ? S_STAGE_START : S_IDLE;
        w_next_active = w_after < NUM_STAGES ? AW'(w_after) : r_active;
      end else if (w_wdog) w_next = S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end
  // outputs are decoded from the next state so their registers line up with r_state
  always_comb begin
    w_vga = w_next == S_IDLE || w_next == S_ERROR;
    w_busy = !w_vga;
    w_init = w_next == S_UART_RX && r_state != S_UART_RX;
    w_rx_en = w_next == S_UART_RX && r_state == S_UART_RX;
    w_error = w_next == S_ERROR;
    w_start = w_next == S_STAGE_START ? NUM_STAGES'(1) << w_next_active : '0;
  end
  assign stage_start = r_start;
  assign UART_rx_initialize = r_init;
  assign UART_rx_enable = r_rx_en;
  assign VGA_enable = r_vga;
  assign busy = r_busy;
  assign error = r_error;
  assign active_stage = r_active;
  sram_client_mux #(
    .NUM_STAGES(NUM_STAGES),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .AW(AW)
  ) u_mux (
    .i_state(r_state),
    .i_index(r_active),
    .i_vga_address(VGA_SRAM_address),
    .i_uart_address(UART_SRAM_address),
    .i_uart_write_data(UART_SRAM_write_data),
    .i_uart_we_n(UART_SRAM_we_n),
    .i_stage_address(stage_address),
    .i_stage_write_data(stage_write_data),
    .i_stage_we_n(stage_we_n),
    .o_address(SRAM_address),
    .o_write_data(SRAM_write_data),
    .o_we_n(SRAM_we_n)
  );
endmodule
